exe_mul_iter: RTL and testbench
===============================

Name: exe_mul_iter

Overview:
- Iterative 32x32 signed/unsigned multiplier in the EXE stage; retires 2 multiplier bits per cycle by default.
- Produces the 64-bit product for MUL/MULT/MULTU (HI/LO write path).
- Its low word drives the ALU's MUL_Out input.
- Asserts a combinational busy so the pipeline control stalls EXE until the product is ready.

Parameters:
- ITER_BITS, 2, multiplier bits retired per CALC cycle; legal values 1, 2, 4. CALC lasts N = 32/ITER_BITS cycles.

Ports:
- clk  input  1  core clock.
- resetn  input  1  synchronous, active-low reset.
- MUL_Start  input  1  request a multiply; sampled only in IDLE.
- MUL_Signed  input  1  1 = signed (MUL/MULT), 0 = unsigned (MULTU); sampled with MUL_Start.
- MUL_Flush  input  1  pipeline flush (exception/eret); aborts any operation.
- MUL_Hold  input  1  downstream stall; keeps DONE state and result valid.
- EXE_ResultA  input  32  multiplicand (forwarded rs).
- EXE_ResultB  input  32  multiplier (forwarded rt).
- MUL_Busy  output  1  combinational; EXE must stall while high.
- MUL_Done  output  1  product valid (registered state decode).
- MUL_Out  output  32  product[31:0], to the ALU.
- MUL_Hi  output  32  product[63:32].
- MUL_Lo  output  32  product[31:0] (same value as MUL_Out).

Behaviour:
- Interface: one clock, clk. resetn is synchronous and active-low. When resetn=0 at an edge: state becomes IDLE; acc, mcand, mplier, neg and cnt become 0; MUL_Done, MUL_Hi, MUL_Lo and MUL_Out become 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If MUL_Start=1 and MUL_Flush=0: latch operands.
    - mcand = |A| and mplier = |B| when signed; raw values when unsigned. |0x80000000| = 0x80000000 as unsigned.
    - neg = MUL_Signed & (A[31] ^ B[31]).
    - acc = 0, cnt = 0. Go to CALC.
  - Otherwise stay in IDLE.
- CALC:
  - Each cycle: acc += (mcand * mplier[ITER_BITS-1:0]) << (cnt*ITER_BITS), all arithmetic 64-bit unsigned.
  - Then mplier >>= ITER_BITS and cnt++.
  - After N cycles (cnt == N-1 at the edge): go to FIX.
- FIX: if neg, acc = 0 - acc (64-bit two's complement). Register MUL_Hi/MUL_Lo/MUL_Out from the final acc. Go to DONE.
- DONE:
  - MUL_Done=1.
  - Stay in DONE while MUL_Hold=1. Go to IDLE when MUL_Hold=0.
  - MUL_Start in DONE is ignored. A new multiply starts only from IDLE, on the cycle after EXE advances.
- MUL_Busy = (IDLE & MUL_Start & ~MUL_Flush) | CALC | FIX. Busy is 0 in DONE so EXE can advance.
- Latency: start in cycle 0 → CALC in cycles 1..N → FIX in cycle N+1 → MUL_Done in cycle N+2 (cycle 18 for ITER_BITS=2). MUL_Busy is high in cycles 0..N+1.
- MUL_Flush:
  - Highest priority after reset. From any state, the next state is IDLE and MUL_Done=0.
  - MUL_Hi/Lo/Out keep their last values and are not updated by an aborted operation.
  - Flush together with Start in IDLE: the start is dropped and MUL_Busy=0.
- Reset asserted mid-CALC: immediate return to IDLE with all outputs 0 at that edge. No partial result is exposed.
- Result registers change only on the FIX→DONE edge. They are stable at all other times, including IDLE, which allows late HI/LO reads.
- Operand inputs are ignored after the latch cycle, so forwarding changes during CALC have no effect.

Test Plan:
- Unsigned basic: A=7, B=6, Signed=0, Start one cycle, Hold=0 → Busy high cycles 0..17; Done at cycle 18 only; Hi=0x00000000, Lo=MUL_Out=0x0000002A; back to IDLE at cycle 19.
- Signed mixed: A=0xFFFFFFFD (-3), B=5, Signed=1 → Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Repeat with Signed=0 → Hi=0x00000004, Lo=0xFFFFFFF1.
- Extremes:
  - Signed 0x80000000*0x80000000 → Hi=0x40000000, Lo=0x00000000.
  - Unsigned 0xFFFFFFFF*0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001.
  - Signed 0xFFFFFFFF*0xFFFFFFFF → Hi=0, Lo=1.
- Hold and back-to-back:
  - Hold=1 for 3 cycles at DONE → Done stays high 4 cycles with stable result.
  - Start asserted during DONE is ignored.
  - Start in the first IDLE cycle afterwards begins a new operation with Done 18 cycles later.
- Flush mid-operation: previous result Hi/Lo=0x0/0x2A; start 9*9; assert Flush in cycle 5 → IDLE in cycle 6, Busy=0, Done never rises, Hi/Lo remain 0x0/0x2A. Flush with Start in the same IDLE cycle → Busy=0, no operation.
- Reset: resetn=0 for one edge during cycle 10 of CALC → all outputs 0, state IDLE. With ITER_BITS=1 and ITER_BITS=4, 7*6 gives Done at cycles 34 and 10 respectively, each with Lo=0x2A.

Source files
------------

// File: rtl/exe_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : exe_mul_iter
// Purpose  : Iterative 32x32 signed/unsigned multiplier for the EXE stage.
//            Retires ITER_BITS multiplier bits per cycle, applies the sign in
//            a final FIX cycle and holds the 64-bit product in HI/LO.
// Revision : 1.0  initial release
// ============================================================================
module exe_mul_iter #(
  parameter int ITER_BITS = 2   // 1, 2 or 4 multiplier bits per CALC cycle
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        MUL_Start,
  input  logic        MUL_Signed,
  input  logic        MUL_Flush,
  input  logic        MUL_Hold,
  input  logic [31:0] EXE_ResultA,
  input  logic [31:0] EXE_ResultB,
  output logic        MUL_Busy,
  output logic        MUL_Done,
  output logic [31:0] MUL_Out,
  output logic [31:0] MUL_Hi,
  output logic [31:0] MUL_Lo
);

  localparam int         N        = 32 / ITER_BITS;
  localparam logic [5:0] CNT_LAST = 6'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [63:0]    acc_q;
  logic [31:0]    mcand_q;
  logic [31:0]    mplier_q;
  logic           neg_q;
  logic [5:0]     cnt_q;
  logic [31:0]    hi_q;
  logic [31:0]    lo_q;

  logic           start_ok;
  logic [31:0]    abs_a;
  logic [31:0]    abs_b;
  logic [ITER_BITS-1:0] digit;
  logic [6:0]     shamt;
  logic [63:0]    partial;
  logic [63:0]    addend;
  logic [63:0]    final_acc;

  // A start is accepted only from IDLE and only when no flush is pending.
  assign start_ok = (state_q == S_IDLE) && MUL_Start && !MUL_Flush;

  // Signed operands are converted to magnitudes; 0x80000000 stays 0x80000000.
  assign abs_a = (MUL_Signed && EXE_ResultA[31]) ? (32'd0 - EXE_ResultA) : EXE_ResultA;
  assign abs_b = (MUL_Signed && EXE_ResultB[31]) ? (32'd0 - EXE_ResultB) : EXE_ResultB;

  // Partial product of the current multiplier digit, aligned to its weight.
  assign digit     = mplier_q[ITER_BITS-1:0];
  assign shamt     = 7'(cnt_q) * 7'(ITER_BITS);
  assign partial   = {32'd0, mcand_q} * 64'(digit);
  assign addend    = partial << shamt;
  assign final_acc = neg_q ? (64'd0 - acc_q) : acc_q;

  // Result is exposed only through the registered HI/LO copies.
  assign MUL_Done = (state_q == S_DONE);
  assign MUL_Hi   = hi_q;
  assign MUL_Lo   = lo_q;
  assign MUL_Out  = lo_q;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and busy decode; flush overrides every transition.
  always_comb begin
    state_d  = state_q;
    MUL_Busy = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d  = S_CALC;
          MUL_Busy = 1'b1;
        end
      end
      S_CALC: begin
        MUL_Busy = 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        MUL_Busy = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (!MUL_Hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (MUL_Flush) state_d = S_IDLE;
  end

  // Datapath: operand latch, shift-add iterations, sign fix and result capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_q    <= 64'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      neg_q    <= 1'b0;
      cnt_q    <= 6'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            mcand_q  <= abs_a;
            mplier_q <= abs_b;
            neg_q    <= MUL_Signed & (EXE_ResultA[31] ^ EXE_ResultB[31]);
            acc_q    <= 64'd0;
            cnt_q    <= 6'd0;
          end
        end
        S_CALC: begin
          if (!MUL_Flush) begin
            acc_q    <= acc_q + addend;
            mplier_q <= mplier_q >> ITER_BITS;
            cnt_q    <= cnt_q + 6'd1;
          end
        end
        S_FIX: begin
          // An aborted operation must never reach the result registers.
          if (!MUL_Flush) begin
            acc_q <= final_acc;
            hi_q  <= final_acc[63:32];
            lo_q  <= final_acc[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_mul_iter
// Purpose  : Self-checking bench for exe_mul_iter. Three instances
//            (ITER_BITS = 2, 1, 4) share stimulus and are compared every cycle
//            against a cycle-count/arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_exe_mul_iter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] opa = 32'd0;
  logic [31:0] opb = 32'd0;

  logic [2:0]  busy_w;
  logic [2:0]  done_w;
  logic [31:0] hi_w  [3];
  logic [31:0] lo_w  [3];
  logic [31:0] out_w [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_mul_iter #(.ITER_BITS(2)) dut (
    .clk(clk), .resetn(resetn), .MUL_Start(start), .MUL_Signed(sgn),
    .MUL_Flush(flush), .MUL_Hold(hold), .EXE_ResultA(opa), .EXE_ResultB(opb),
    .MUL_Busy(busy_w[0]), .MUL_Done(done_w[0]), .MUL_Out(out_w[0]),
    .MUL_Hi(hi_w[0]), .MUL_Lo(lo_w[0]));

  exe_mul_iter #(.ITER_BITS(1)) dut1 (
    .clk(clk), .resetn(resetn), .MUL_Start(start), .MUL_Signed(sgn),
    .MUL_Flush(flush), .MUL_Hold(hold), .EXE_ResultA(opa), .EXE_ResultB(opb),
    .MUL_Busy(busy_w[1]), .MUL_Done(done_w[1]), .MUL_Out(out_w[1]),
    .MUL_Hi(hi_w[1]), .MUL_Lo(lo_w[1]));

  exe_mul_iter #(.ITER_BITS(4)) dut4 (
    .clk(clk), .resetn(resetn), .MUL_Start(start), .MUL_Signed(sgn),
    .MUL_Flush(flush), .MUL_Hold(hold), .EXE_ResultA(opa), .EXE_ResultB(opb),
    .MUL_Busy(busy_w[2]), .MUL_Done(done_w[2]), .MUL_Out(out_w[2]),
    .MUL_Hi(hi_w[2]), .MUL_Lo(lo_w[2]));

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 running (age = cycles since start), 2 result valid
  int          NN [3] = '{16, 32, 8};
  int          m_phase [3];
  int          m_age   [3];
  logic [63:0] m_pend  [3];
  logic [31:0] m_hi    [3];
  logic [31:0] m_lo    [3];
  bit          m_init = 1'b0;
  int          cyc = 0;
  int          t0 = 0;
  int          first_done [3];

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b,
                                       input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc=%0d got %0h expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (!resetn) begin
        m_phase[k] = 0;
        m_hi[k]    = 32'd0;
        m_lo[k]    = 32'd0;
        m_init     = 1'b1;
      end else if (flush) begin
        m_phase[k] = 0;
      end else begin
        case (m_phase[k])
          0: if (start) begin
               m_phase[k] = 1;
               m_age[k]   = 1;
               m_pend[k]  = prod(opa, opb, sgn);
             end
          1: if (m_age[k] == NN[k] + 1) begin
               m_phase[k] = 2;
               m_hi[k]    = m_pend[k][63:32];
               m_lo[k]    = m_pend[k][31:0];
             end else begin
               m_age[k]++;
             end
          default: if (!hold) m_phase[k] = 0;
        endcase
      end
    end
  end

  // Compare every output of every instance on each falling edge.
  always @(negedge clk) begin
    if (m_init) begin
      for (int k = 0; k < 3; k++) begin
        chk("busy", k, 64'(busy_w[k]),
            64'((m_phase[k] == 0 && start && !flush) || m_phase[k] == 1));
        chk("done", k, 64'(done_w[k]), 64'(m_phase[k] == 2));
        chk("hi",   k, 64'(hi_w[k]),  64'(m_hi[k]));
        chk("lo",   k, 64'(lo_w[k]),  64'(m_lo[k]));
        chk("out",  k, 64'(out_w[k]), 64'(m_lo[k]));
        if (done_w[k] && first_done[k] < 0) first_done[k] = cyc - t0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_obs();
    t0 = cyc;
    for (int k = 0; k < 3; k++) first_done[k] = -1;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle (cycle 0), then scrambles operands.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    next_cyc();
    opa = a; opb = b; sgn = s; start = 1'b1;
    clear_obs();
    next_cyc();
    start = 1'b0;
    opa = $urandom; opb = $urandom; sgn = $urandom_range(0, 1);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) next_cyc();
  endtask

  // Full operation with hand-computed expected product on every instance.
  task automatic lit_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] ehi, input logic [31:0] elo);
    start_op(a, b, s);
    wait_cyc(40);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_hi"}, k, 64'(hi_w[k]), 64'(ehi));
      chk({nm, "_lo"}, k, 64'(lo_w[k]), 64'(elo));
    end
    chk({nm, "_model_hi"}, 0, 64'(m_hi[0]), 64'(ehi));
    chk({nm, "_model_lo"}, 0, 64'(m_lo[0]), 64'(elo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int k = 0; k < 3; k++) first_done[k] = -1;
    wait_cyc(3);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_done", k, 64'(done_w[k]), 64'd0);
      chk("rst_lo",   k, 64'(lo_w[k]),   64'd0);
    end

    // Unsigned basic with latency for each ITER_BITS.
    lit_op("u7x6", 32'd7, 32'd6, 1'b0, 32'h0, 32'h2A);
    chk("lat_iter2", 0, 64'(first_done[0]), 64'd18);
    chk("lat_iter1", 1, 64'(first_done[1]), 64'd34);
    chk("lat_iter4", 2, 64'(first_done[2]), 64'd10);

    lit_op("smix",  32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    lit_op("umix",  32'hFFFF_FFFD, 32'd5, 1'b0, 32'h0000_0004, 32'hFFFF_FFF1);
    lit_op("smin",  32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0);
    lit_op("umax",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h1);
    lit_op("sm1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h1);

    // Hold at DONE with start ignored, then back-to-back start.
    hold = 1'b1;
    start_op(32'd3, 32'd4, 1'b0);
    wait_cyc(36);
    start = 1'b1; opa = 32'd5; opb = 32'd5;
    wait_cyc(3);
    for (int k = 0; k < 3; k++) begin
      chk("hold_done", k, 64'(done_w[k]), 64'd1);
      chk("hold_lo",   k, 64'(lo_w[k]),   64'd12);
    end
    start = 1'b0; hold = 1'b0;
    start_op(32'd6, 32'd7, 1'b0);
    wait_cyc(40);
    chk("b2b_lat", 0, 64'(first_done[0]), 64'd18);
    chk("b2b_lo",  0, 64'(lo_w[0]), 64'h2A);

    // Flush in cycle 5 of a 9*9 after a 7*6 result.
    lit_op("pre", 32'd7, 32'd6, 1'b0, 32'h0, 32'h2A);
    start_op(32'd9, 32'd9, 1'b0);
    wait_cyc(4);
    flush = 1'b1;
    next_cyc();
    flush = 1'b0;
    chk("flush_busy", 0, 64'(busy_w[0]), 64'd0);
    wait_cyc(40);
    for (int k = 0; k < 3; k++) begin
      chk("flush_nodone", k, 64'(first_done[k]), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("flush_lo",     k, 64'(lo_w[k]), 64'h2A);
    end

    // Flush together with start: no operation.
    next_cyc();
    start = 1'b1; flush = 1'b1; opa = 32'd9; opb = 32'd9;
    clear_obs();
    @(negedge clk);
    chk("fs_busy", 0, 64'(busy_w[0]), 64'd0);
    next_cyc();
    start = 1'b0; flush = 1'b0;
    wait_cyc(40);
    chk("fs_nodone", 0, 64'(first_done[0]), 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset during cycle 10 of CALC.
    start_op(32'd9, 32'd9, 1'b0);
    wait_cyc(9);
    resetn = 1'b0;
    next_cyc();
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("mrst_hi",   k, 64'(hi_w[k]),   64'd0);
      chk("mrst_lo",   k, 64'(lo_w[k]),   64'd0);
      chk("mrst_done", k, 64'(done_w[k]), 64'd0);
    end
    lit_op("post_rst", 32'd7, 32'd6, 1'b0, 32'h0, 32'h2A);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 4000; i++) begin
      next_cyc();
      start  = ($urandom_range(0, 2) == 0);
      sgn    = $urandom_range(0, 1);
      opa    = pick();
      opb    = pick();
      hold   = ($urandom_range(0, 2) == 0);
      flush  = ($urandom_range(0, 59) == 0);
      resetn = ($urandom_range(0, 799) != 0);
    end
    next_cyc();
    start = 1'b0; hold = 1'b0; flush = 1'b0; resetn = 1'b1;
    wait_cyc(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
